bram_dp: RTL
============

BRAM_DP -- requirements
Module: bram_dp

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, address bits per port; DEPTH = 2**ADDR_WIDTH words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, write-enable granularity; DATA_WIDTH SHALL be a multiple of BYTE_WIDTH, so NB = DATA_WIDTH/BYTE_WIDTH.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2 cycles.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-port read-during-write behaviour: 0 = read-first, 1 = write-first.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill memory after reset when 1.
REQ-007 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-008 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-009 SHALL have ports: a_en  in  1  port A access request.
REQ-010 SHALL have ports: a_we  in  NB  port A byte write enables.
REQ-011 SHALL have ports: a_addr  in  ADDR_WIDTH  port A address.
REQ-012 SHALL have ports: a_wdata  in  DATA_WIDTH  port A write data.
REQ-013 SHALL have ports: a_rdata  out  DATA_WIDTH  port A read data.
REQ-014 SHALL have ports: a_rvalid  out  1  port A read data valid.
REQ-015 SHALL have ports b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid, identical to port A.
REQ-016 SHALL have ports: init_done  out  1  memory ready; requests are accepted only while init_done is high.

Function
REQ-017 SHALL implement a controller FSM with states CLEAR and READY.
REQ-018 On rst_n release with CLEAR_ON_RESET=1, the FSM SHALL enter CLEAR and write zero to addresses 0..DEPTH-1, one per cycle, in ascending order.
REQ-019 The clear sequence SHALL take exactly DEPTH cycles, after which the FSM SHALL go to READY and set init_done=1 on the same edge as the last clear write.
REQ-020 With CLEAR_ON_RESET=0, the FSM SHALL go straight to READY, and init_done SHALL rise on the first rising clk edge after rst_n release.
REQ-021 During CLEAR, a_en and b_en SHALL be ignored: no writes and no rvalid.
REQ-022 An access is accepted when x_en=1 and init_done=1; every accepted access SHALL perform a read, whatever x_we is.
REQ-023 Byte lane i of x_wdata, bits [i*BYTE_WIDTH +: BYTE_WIDTH], SHALL be written only when x_we[i]=1; other lanes SHALL be preserved.
REQ-024 For an accepted access at edge T, x_rdata SHALL be valid and x_rvalid=1 after edge T+READ_LATENCY-1+1, i.e. 1 or 2 edges later.
REQ-025 x_rvalid SHALL pulse high for exactly one cycle per accepted access; back-to-back accesses SHALL give back-to-back rvalid with full throughput.
REQ-026 x_rdata SHALL hold its last value when no rvalid is pending.
REQ-027 Same-port write with read: RDW_MODE=0 SHALL return the old word; RDW_MODE=1 SHALL return the merged new word (written lanes new, others old).
REQ-028 Cross-port read of an address written in the same cycle SHALL return the old word.
REQ-029 If both ports write the same address in the same cycle, port A's enabled lanes SHALL win; port B SHALL write only the lanes A does not enable.
REQ-030 Addresses SHALL be used modulo DEPTH; no out-of-range condition exists.

Reset
REQ-031 While rst_n=0: a_rdata=0, b_rdata=0, a_rvalid=0, b_rvalid=0, init_done=0, clear address counter=0.
REQ-032 Reset asserted mid-clear SHALL abort the sweep; release SHALL restart the clear from address 0.
REQ-033 Reset mid-access SHALL flush the read pipeline (no rvalid after release for pre-reset accesses).
REQ-034 Memory contents SHALL NOT be reset asynchronously; with CLEAR_ON_RESET=0, contents SHALL survive reset.

Verification
REQ-035 ADDR_WIDTH=4, CLEAR_ON_RESET=1: release reset, preload 0xFFFFFFFF at addr 5 attempted during CLEAR -> ignored; init_done rises after 16 cycles; read addr 5 -> 0x00000000.
REQ-036 READ_LATENCY=2: A writes 0x12345678 to addr 3, then reads addr 3 -> a_rvalid exactly 2 edges after read acceptance, a_rdata=0x12345678.
REQ-037 Byte enables: word 0xAABBCCDD at addr 7, write a_we=4'b0101 data 0x11223344 -> read returns 0xAA22CC44.
REQ-038 RDW: addr 2 holds 0x1, write 0x2 with we=all -> RDW_MODE=0 returns 0x1, RDW_MODE=1 returns 0x2; same-cycle B read of addr 2 returns 0x1.
REQ-039 Collision: A writes 0x000000AA we=0001, B writes 0xBBBBBBBB we=1111 to addr 9 in the same cycle -> read returns 0xBBBBBBAA.
REQ-040 Assert rst_n=0 at clear address 8, then release -> init_done=0 for a further 16 cycles, and every address reads zero afterwards.

Source files
------------

// File: rtl/bram_dp.sv
// bram_dp: true dual-port byte-writable RAM with a
// power-up zero sweep and a 1- or 2-cycle read pipeline.

module bram_dp_rd_pipe #(
  parameter int DW   = 32,
  parameter bit LAT2 = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  logic          v0;
  logic          v1;
  logic [DW-1:0] d0;
  logic [DW-1:0] d1;
  logic          t_v;
  logic [DW-1:0] t_d;

  // Stage 1 only sits in the path for the 2-cycle flavour.
  assign t_v = LAT2 ? v1 : v0;
  assign t_d = LAT2 ? d1 : d0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0     <= 1'b0;
      v1     <= 1'b0;
      d0     <= '0;
      d1     <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      v0 <= in_vld;
      if (in_vld) begin
        d0 <= in_data;
      end
      v1 <= v0;
      if (v0) begin
        d1 <= d0;
      end
      rvalid <= t_v;
      if (t_v) begin
        rdata <= t_d;
      end
    end
  end

endmodule

module bram_dp #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NB = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_en,
  input  logic [NB-1:0]         a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_en,
  input  logic [NB-1:0]         b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  b_rvalid,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit CLR   = (CLEAR_ON_RESET != 0);
  localparam bit WF    = (RDW_MODE != 0);
  localparam bit LAT2  = (READ_LATENCY == 2);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t                  state;
  state_t                  state_n;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    clr_we;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    a_acc;
  logic                    b_acc;
  logic [DATA_WIDTH-1:0]   a_old;
  logic [DATA_WIDTH-1:0]   b_old;
  logic [DATA_WIDTH-1:0]   a_mrg;
  logic [DATA_WIDTH-1:0]   b_mrg;
  logic [DATA_WIDTH-1:0]   a_rd;
  logic [DATA_WIDTH-1:0]   b_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      clr_addr  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      init_done <= (state_n == S_READY);
      if (clr_we) begin
        clr_addr <= clr_addr + ADDR_WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_n = state;
    clr_we  = 1'b0;
    unique case (state)
      S_CLEAR: begin
        if (!CLR) begin
          state_n = S_READY;
        end else begin
          clr_we = rst_n;
          if (&clr_addr) begin
            state_n = S_READY;
          end
        end
      end
      S_READY: begin
        state_n = S_READY;
      end
      default: begin
        state_n = S_CLEAR;
      end
    endcase
  end

  assign a_acc = a_en & init_done;
  assign b_acc = b_en & init_done;

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  always_comb begin
    a_mrg = a_old;
    b_mrg = b_old;
    for (int i = 0; i < NB; i++) begin
      if (a_we[i]) begin
        a_mrg[i*BYTE_WIDTH +: BYTE_WIDTH] =
          a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (b_we[i]) begin
        b_mrg[i*BYTE_WIDTH +: BYTE_WIDTH] =
          b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign a_rd = WF ? a_mrg : a_old;
  assign b_rd = WF ? b_mrg : b_old;

  // Port A is applied last so its lanes win a same-address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end
    for (int i = 0; i < NB; i++) begin
      if (b_acc && b_we[i]) begin
        mem[b_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
          b_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (a_acc && a_we[i]) begin
        mem[a_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
          a_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  bram_dp_rd_pipe #(
    .DW   (DATA_WIDTH),
    .LAT2 (LAT2)
  ) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (a_acc),
    .in_data (a_rd),
    .rdata   (a_rdata),
    .rvalid  (a_rvalid)
  );

  bram_dp_rd_pipe #(
    .DW   (DATA_WIDTH),
    .LAT2 (LAT2)
  ) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (b_acc),
    .in_data (b_rd),
    .rdata   (b_rdata),
    .rvalid  (b_rvalid)
  );

endmodule
